c64_dma_arbiter: RTL

//  Owns the C64 expansion-port DMA handshake for the REU. Turns the REU's dma_req into a

---
 rtl/c64_bus_pkg.sv | 30 +++
 rtl/dma_window_timer.sv | 47 ++++
 rtl/c64_dma_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/c64_bus_pkg.sv
// Shared C64 bus definitions for the REU DMA arbiter.
// FSM state encodings, default phi2 window length, clock/phi ratio and a
// saturating counter helper used when DMA_CYCLE_COUNT_EN is defined.
package c64_bus_pkg;

   // System clock cycles per phi period
   localparam int PHI_RATIO     = 32;
   // Default dma_cycle window length in clk
   localparam int PHI2_CLKS_DEF = 16;

   typedef logic [2:0] dma_state_t;

   localparam dma_state_t ST_IDLE = 3'd0;
   localparam dma_state_t ST_HALT = 3'd1;
   localparam dma_state_t ST_OWN  = 3'd2;
   localparam dma_state_t ST_WIN  = 3'd3;
   localparam dma_state_t ST_REL  = 3'd4;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dma_window_timer.sv
// Times one dma_cycle window: loads on start, stays active for exactly
// PHI2_CLKS clocks, flags the final clock with last.
module dma_window_timer
   import c64_bus_pkg::*;
#(
   parameter int PHI2_CLKS = PHI2_CLKS_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic active,
   output logic last
);

   localparam int CW = (PHI2_CLKS > 1) ? $clog2(PHI2_CLKS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(PHI2_CLKS - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [CW-1:0] count_r;
   logic          active_r;

   // Load on start, count 0..PHI2_CLKS-1, drop active after the last count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r  <= '0;
         active_r <= 1'b0;
      end else if (start && !active_r) begin
         count_r  <= '0;
         active_r <= 1'b1;
      end else if (active_r) begin
         if (count_r == LAST_CNT) begin
            count_r  <= '0;
            active_r <= 1'b0;
         end else begin
            count_r  <= count_r + ONE_CNT;
            active_r <= 1'b1;
         end
      end else begin
         count_r  <= count_r;
         active_r <= active_r;
      end
   end

   assign active = active_r;
   assign last   = active_r && (count_r == LAST_CNT);

endmodule

// File: rtl/c64_dma_arbiter.sv
// C64 expansion-port DMA arbiter for the REU.
// Converts dma_req into a safe 6510 halt (RDY low, then AEC low once the CPU
// is stalled on a read) and grants phi2 slots as PHI2_CLKS-long dma_cycle
// windows. Define DMA_CYCLE_COUNT_EN to add the dma_slots window counter.
module c64_dma_arbiter
   import c64_bus_pkg::*;
#(
   parameter int PHI2_CLKS = PHI2_CLKS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        phi2_start,
   input  logic        vic_ba,
   input  logic        cpu_we,
   input  logic        dma_req,
   output logic        dma_cycle,
   output logic        cpu_rdy,
   output logic        cpu_aec,
   output logic        dma_busy
`ifdef DMA_CYCLE_COUNT_EN
   ,
   output logic [15:0] dma_slots
`endif
);

   dma_state_t state_r;
   dma_state_t state_s;
   logic       rdy_r;
   logic       rdy_s;
   logic       aec_r;
   logic       aec_s;
   logic       busy_r;
   logic       win_start_s;
   logic       win_active_s;
   logic       win_last_s;
   logic       halt_entry_s;

   dma_window_timer #(
      .PHI2_CLKS (PHI2_CLKS)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (win_start_s),
      .active (win_active_s),
      .last   (win_last_s)
   );

   // Next-state and next-output decode; a window never starts on the slot
   // that confirmed the stall because OWN only reacts to a later phi2_start
   always_comb begin
      state_s      = state_r;
      rdy_s        = rdy_r;
      aec_s        = aec_r;
      win_start_s  = 1'b0;
      halt_entry_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (dma_req) begin
               state_s      = ST_HALT;
               rdy_s        = 1'b0;
               halt_entry_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HALT: begin
            // A write cycle cannot be stalled by RDY; wait for a read
            if (phi2_start && !cpu_we) begin
               state_s = ST_OWN;
               aec_s   = 1'b0;
            end else begin
               state_s = ST_HALT;
            end
         end
         ST_OWN: begin
            if (phi2_start) begin
               if (dma_req && vic_ba) begin
                  state_s     = ST_WIN;
                  win_start_s = 1'b1;
               end else if (dma_req) begin
                  state_s = ST_OWN;
               end else begin
                  state_s = ST_REL;
               end
            end else begin
               state_s = ST_OWN;
            end
         end
         ST_WIN: begin
            if (win_last_s) begin
               state_s = ST_OWN;
            end else begin
               state_s = ST_WIN;
            end
         end
         ST_REL: begin
            if (phi2_start) begin
               state_s = ST_IDLE;
               rdy_s   = 1'b1;
               aec_s   = 1'b1;
            end else begin
               state_s = ST_REL;
            end
         end
         default: begin
            state_s = ST_IDLE;
            rdy_s   = 1'b1;
            aec_s   = 1'b1;
         end
      endcase
   end

   // State and CPU control registers; busy tracks the registered state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         rdy_r   <= 1'b1;
         aec_r   <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         rdy_r   <= rdy_s;
         aec_r   <= aec_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   assign dma_cycle = win_active_s;
   assign cpu_rdy   = rdy_r;
   assign cpu_aec   = aec_r;
   assign dma_busy  = busy_r;

`ifdef DMA_CYCLE_COUNT_EN
   logic [15:0] slots_r;

   // Count granted windows since the last IDLE->HALT, saturating
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slots_r <= 16'd0;
      end else if (halt_entry_s) begin
         slots_r <= 16'd0;
      end else if (win_start_s) begin
         slots_r <= sat_inc16(slots_r);
      end else begin
         slots_r <= slots_r;
      end
   end

   assign dma_slots = slots_r;
`endif

endmodule
